peak_bin_detect: RTL
====================

// Module: peak_bin_detect
// PURPOSE
//  Upstream stage of the DOA weight block. After the FFT of mic 1 completes, sweeps
//  the mic-1 FFT RAM over a bin window, computes re^2+im^2 per bin, and reports the
//  strongest bin (maxbin) with a one-cycle detectdone pulse. After detection it holds
//  rdaddr1 at maxbin so ram1q presents the peak bin to the weight block.
// PARAMETERS
//  ADDR_W  10    FFT RAM address width (1024-point FFT)
//  DATA_W  24    RAM word width; [23:12] = signed real, [11:0] = signed imag
//  BIN_LO  1     first bin swept (skips DC)
//  BIN_HI  511   last bin swept (positive-frequency half); BIN_LO <= BIN_HI required
//  THRESH  4096  minimum peak magnitude-squared for found=1
// PORTS
//  clk         in   1       system clock
//  reset       in   1       synchronous, active-high reset
//  fftdone     in   1       start pulse: mic-1 FFT RAM contents valid
//  ram1q       in   24      mic-1 FFT RAM read data, 1-cycle read latency
//  rdaddr1     out  10      mic-1 FFT RAM read address
//  busy        out  1       high from accepted start until detectdone inclusive
//  detectdone  out  1       one-cycle pulse: maxbin/maxmag/found valid
//  maxbin      out  10      bin index of largest magnitude in [BIN_LO,BIN_HI]
//  maxmag      out  24      unsigned re^2+im^2 of maxbin
//  found       out  1       1 if maxmag >= THRESH
// BEHAVIOUR
//  Reset: state=IDLE; rdaddr1=0, busy=0, detectdone=0, maxbin=0, maxmag=0, found=0.
//  States: IDLE -> SWEEP -> DRAIN -> DONE -> IDLE.
//  - IDLE: fftdone sampled high (cycle 0) -> SWEEP; clear running max (mag=0, bin=BIN_LO).
//  - SWEEP: rdaddr1 = BIN_LO at cycle 1, +1 per cycle, BIN_HI at cycle N
//    (N = BIN_HI-BIN_LO+1); after issuing BIN_HI -> DRAIN.
//  - DRAIN: 2 cycles flushing read/magnitude pipeline -> DONE.
//  - DONE: one cycle; detectdone=1 at cycle N+3; outputs update same cycle; -> IDLE.
//  Pipeline: addr k at cycle t; ram1q valid cycle t+1; mag registered (valid t+2);
//  compare/update running max at end of t+2. Valid-tag bit travels with each address.
//  Arithmetic: re,im sign-extended 12-bit; mag = re*re + im*im, 24-bit unsigned,
//  cannot overflow (max 2*2048^2 = 2^23).
//  Compare: update only if mag > running max (strict) -> ties keep the lowest bin.
//  All-zero/below-threshold spectrum: maxbin = BIN_LO (or true max bin), found=0.
//  Bins outside [BIN_LO,BIN_HI] never read, never affect result.
//  busy=1 from cycle 1 through cycle N+3; fftdone while busy ignored (no restart).
//  fftdone coincident with DONE cycle ignored; must be re-asserted in IDLE.
//  After DONE: rdaddr1 = maxbin, held until next accepted start; maxbin/maxmag/found
//  hold until next detectdone.
//  Reset mid-operation: immediate return to reset values; no detectdone emitted;
//  in-flight pipeline data discarded.
// TESTING
//  1 Tone: bin 100 = (re 1000, im 0), others (10,10), fftdone -> detectdone at cycle
//    514, maxbin=100, maxmag=1000000, found=1, rdaddr1=100 afterwards.
//  2 Tie: bins 50 and 200 both (-700,700) -> maxbin=50, maxmag=980000.
//  3 Silence: all bins (0,0) -> maxbin=1, maxmag=0, found=0, detectdone still pulses.
//  4 Window/sign: bin 0 = (2047,2047), bin 300 = (-2048,0) -> maxbin=300,
//    maxmag=4194304; bin 0 never addressed (rdaddr1 in [1,511] during sweep).
//  5 Control: fftdone re-pulsed at cycle 200 -> ignored, single detectdone at 514;
//    reset at cycle 300 -> all outputs 0, no pulse; new fftdone -> clean full sweep.
//  6 Back-to-back: second fftdone cycle 515 -> second result at cycle 515+514.

Source files
------------

// File: rtl/peak_bin_detect.sv
// peak_bin_detect
// Upstream stage of the DOA weight block. Once the mic-1 FFT is complete, this
// block sweeps the FFT RAM over the bin window [BIN_LO, BIN_HI] and computes
// re^2 + im^2 for each bin. It reports the strongest bin with a one-cycle
// detectdone pulse. Afterwards it parks the read address on the winning bin so
// that ram1q keeps presenting the peak to the weight block.
module peak_bin_detect #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 24,
  parameter int BIN_LO = 1,
  parameter int BIN_HI = 511,
  parameter int THRESH = 4096
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fftdone,
  input  logic [DATA_W-1:0] ram1q,
  output logic [ADDR_W-1:0] rdaddr1,
  output logic              busy,
  output logic              detectdone,
  output logic [ADDR_W-1:0] maxbin,
  output logic [DATA_W-1:0] maxmag,
  output logic              found
);

  localparam int                HALF_W    = DATA_W / 2;
  localparam logic [ADDR_W-1:0] FIRST_BIN = ADDR_W'(BIN_LO);
  localparam logic [ADDR_W-1:0] LAST_BIN  = ADDR_W'(BIN_HI);
  localparam logic [DATA_W-1:0] MIN_PEAK  = DATA_W'(THRESH);

  typedef enum logic [1:0] {
    IDLE,
    SWEEP,
    DRAIN,
    DONE
  } stateType;

  stateType          state;
  stateType          nextState;
  logic              drainCnt;
  logic              startAccept;

  logic              dataValid;
  logic [ADDR_W-1:0] dataBin;
  logic              magValid;
  logic [ADDR_W-1:0] magBin;
  logic [DATA_W-1:0] magReg;

  logic [DATA_W-1:0] runMag;
  logic [ADDR_W-1:0] runBin;

  logic [DATA_W-1:0] reExt;
  logic [DATA_W-1:0] imExt;
  logic [DATA_W-1:0] reSq;
  logic [DATA_W-1:0] imSq;
  logic [DATA_W-1:0] magNext;

  logic              candUpdate;
  logic [DATA_W-1:0] candMag;
  logic [ADDR_W-1:0] candBin;

  assign startAccept = (state == IDLE) && fftdone;

  // State register. A synchronous reset abandons any sweep in progress.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Sequencing: a start is only taken in IDLE. The sweep ends after BIN_HI is
  // issued, and two drain cycles empty the read/magnitude pipe. The busy and
  // detectdone flags follow directly from the state.
  always_comb begin
    nextState  = state;
    busy       = 1'b0;
    detectdone = 1'b0;
    case (state)
      IDLE: begin
        if (fftdone) begin
          nextState = SWEEP;
        end
      end
      SWEEP: begin
        busy = 1'b1;
        if (rdaddr1 == LAST_BIN) begin
          nextState = DRAIN;
        end
      end
      DRAIN: begin
        busy = 1'b1;
        if (drainCnt) begin
          nextState = DONE;
        end
      end
      DONE: begin
        busy       = 1'b1;
        detectdone = 1'b1;
        nextState  = IDLE;
      end
      default: begin
        nextState = IDLE;
      end
    endcase
  end

  // Magnitude squared of the word currently on ram1q. Real and imaginary parts
  // are sign-extended to full width first. The true result is below 2^23+1, so
  // keeping only the low DATA_W bits of each product is exact.
  always_comb begin
    reExt   = {{HALF_W{ram1q[DATA_W-1]}}, ram1q[DATA_W-1:HALF_W]};
    imExt   = {{HALF_W{ram1q[HALF_W-1]}}, ram1q[HALF_W-1:0]};
    reSq    = reExt * reExt;
    imSq    = imExt * imExt;
    magNext = reSq + imSq;
  end

  // Candidate running maximum after the magnitude now in the compare stage is
  // taken into account. The strict compare leaves ties on the lowest bin.
  always_comb begin
    candUpdate = magValid && (magReg > runMag);
    candMag    = candUpdate ? magReg : runMag;
    candBin    = candUpdate ? magBin : runBin;
  end

  // Read-data and magnitude pipeline. A valid tag and a bin index travel with
  // each issued address. The running maximum is cleared on start and otherwise
  // follows the candidate.
  always_ff @(posedge clk) begin
    if (reset) begin
      dataValid <= 1'b0;
      dataBin   <= '0;
      magValid  <= 1'b0;
      magBin    <= '0;
      magReg    <= '0;
      runMag    <= '0;
      runBin    <= '0;
    end else begin
      dataValid <= (state == SWEEP);
      dataBin   <= rdaddr1;
      magValid  <= dataValid;
      magBin    <= dataBin;
      magReg    <= magNext;
      if (startAccept) begin
        runMag <= '0;
        runBin <= FIRST_BIN;
      end else begin
        runMag <= candMag;
        runBin <= candBin;
      end
    end
  end

  // Address generation and result capture. The address walks the window during
  // SWEEP. The last drain cycle folds in the final magnitude and publishes the
  // result, which appears together with detectdone. The address then rests on
  // the winning bin.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdaddr1  <= '0;
      maxbin   <= '0;
      maxmag   <= '0;
      found    <= 1'b0;
      drainCnt <= 1'b0;
    end else begin
      drainCnt <= (state == DRAIN) ? ~drainCnt : 1'b0;
      case (state)
        IDLE: begin
          if (fftdone) begin
            rdaddr1 <= FIRST_BIN;
          end
        end
        SWEEP: begin
          if (rdaddr1 != LAST_BIN) begin
            rdaddr1 <= rdaddr1 + ADDR_W'(1);
          end
        end
        DRAIN: begin
          if (drainCnt) begin
            rdaddr1 <= candBin;
            maxbin  <= candBin;
            maxmag  <= candMag;
            found   <= (candMag >= MIN_PEAK);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
